nf_ram_dma: RTL
===============

Name: nf_ram_dma

Overview:
- Single-channel DMA initiator that drives the word-addressed single-port RAM interface (addr, we, wd, rd).
- Copies a block of words from a source to a destination, or fills a block with a constant.
- Sits between a control register front-end (start/config strobes) and the RAM port, and owns the port while busy.
- The RAM read path is combinational (rd valid in the same cycle as addr); writes commit on the rising clock edge when we=1.

Parameters:
- depth, 64, RAM depth in 32-bit words; pointer increments wrap modulo depth.

Ports:
- clk  input  1  clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  start request; sampled in IDLE only
- mode  input  1  0 = copy, 1 = fill
- src_addr  input  32  source word index (copy); ignored in fill
- dst_addr  input  32  destination word index
- len  input  32  number of words to transfer
- fill_val  input  32  fill constant (fill mode)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on completion
- ram_addr  output  32  RAM word address
- ram_we  output  1  RAM write enable
- ram_wd  output  32  RAM write data
- ram_rd  input  32  RAM read data (combinational from ram_addr)

Behaviour:
- Reset values: state IDLE; busy=0, done=0, ram_we=0, ram_addr=0, ram_wd=0; internal pointers, counter and data register = 0.
- Reset is asynchronous. Asserting resetn=0 mid-transfer aborts the transfer. ram_we drops immediately and done is not generated. Words already written remain written.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Outputs: ram_we=0, ram_addr=0, ram_wd=0.
  - On start=1 at a clock edge, latch src_addr mod depth, dst_addr mod depth, len, mode and fill_val.
  - If len==0, go to DONE.
  - Otherwise go to READ (copy) or WRITE (fill).
- READ (copy only):
  - ram_addr=src_ptr, ram_we=0.
  - At the clock edge, data_reg <= ram_rd; go to WRITE.
- WRITE:
  - ram_addr=dst_ptr, ram_we=1.
  - ram_wd = data_reg (copy) or latched fill_val (fill).
  - At the clock edge, cnt decrements, and dst_ptr (and src_ptr in copy) increments.
  - If cnt was 1, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: done=1, busy=1, ram_we=0; go to IDLE unconditionally at the next edge.
- Latency, counted from the accepting edge:
  - Copy: done is high in cycle 2*len+1.
  - Fill: done is high in cycle len+1.
  - len=0: done is high in cycle 1.
- Pointer wrap: a pointer at depth-1 increments to 0.
- Counter width: len is a full 32 bits; no truncation.
- start while busy (including DONE) is ignored; no queuing. start held high through DONE re-triggers in the following IDLE cycle.
- Config inputs are sampled only at the accepting edge. Later changes have no effect on the running transfer.
- Overlapping regions are copied strictly forward, one word at a time. If dst is inside (src, src+len), already-copied words propagate; this is defined behaviour, not an error.
- The read and write addresses are never presented in the same cycle, so the RAM sees exactly one access per cycle.

Test Plan:
- Preload RAM[0..3]={A0,A1,A2,A3}; copy src=0, dst=8, len=4 -> RAM[8..11]=A0..A3; done pulses in cycle 9; busy is high in cycles 1..9; ram_we is high in cycles 2,4,6,8.
- Fill dst=60, len=6, fill_val=0xDEADBEEF, depth=64 -> RAM[60..63] and RAM[0..1]=0xDEADBEEF; done in cycle 7; ram_we high in cycles 1..6.
- len=0 with start -> no ram_we pulse; done in cycle 1; busy high for exactly one cycle.
- Assert start with new config during a copy of len=3 -> the second request is ignored; only the first destination is written; exactly one done pulse.
- Drive resetn=0 during the WRITE of word 2 of a len=4 fill -> ram_we=0 asynchronously; state IDLE; no done; only word 0 (and word 1 if its edge passed) is written.
- Overlap copy: RAM[0..3]={1,2,3,4}, src=0, dst=1, len=3 -> RAM[0..3]={1,1,1,1}.

Source files
------------

// File: rtl/nf_ram_dma.sv
// Single-channel DMA initiator for a word-addressed single-port RAM.
// Copies a block (read/write alternating) or fills a block with a constant.
module nf_ram_dma #(
   parameter int unsigned depth = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        mode,
   input  logic [31:0] src_addr,
   input  logic [31:0] dst_addr,
   input  logic [31:0] len,
   input  logic [31:0] fill_val,
   output logic        busy,
   output logic        done,
   output logic [31:0] ram_addr,
   output logic        ram_we,
   output logic [31:0] ram_wd,
   input  logic [31:0] ram_rd
);

   localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
   typedef logic [AW-1:0] ptr_t;

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e      state_q, state_d;
   ptr_t        src_ptr_q, dst_ptr_q;
   logic [31:0] cnt_q, data_q, fill_q;
   logic        mode_q;

   // Explicit wrap so non-power-of-two depths behave as modulo depth.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(depth - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      busy     = 1'b1;
      done     = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_wd   = '0;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (start) begin
               if (len == '0)  state_d = StDone;
               else if (mode)  state_d = StWrite;
               else            state_d = StRead;
            end
         end
         StRead: begin
            ram_addr = 32'(src_ptr_q);
            state_d  = StWrite;
         end
         StWrite: begin
            ram_addr = 32'(dst_ptr_q);
            ram_we   = 1'b1;
            ram_wd   = mode_q ? fill_q : data_q;
            if (cnt_q == 32'd1) state_d = StDone;
            else if (mode_q)    state_d = StWrite;
            else                state_d = StRead;
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         fill_q    <= '0;
         mode_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  src_ptr_q <= ptr_t'(src_addr % depth);
                  dst_ptr_q <= ptr_t'(dst_addr % depth);
                  cnt_q     <= len;
                  mode_q    <= mode;
                  fill_q    <= fill_val;
               end
            end
            StRead: data_q <= ram_rd;
            StWrite: begin
               cnt_q     <= cnt_q - 32'd1;
               dst_ptr_q <= ptr_inc(dst_ptr_q);
               if (!mode_q) src_ptr_q <= ptr_inc(src_ptr_q);
            end
            default: ;
         endcase
      end
   end

endmodule
